// File: rtl/shader_core_simd.sv
// SIMD shader core: one 16-bit instruction broadcast to LANES lanes through a 2-stage EX -> result pipeline.
// Optional macro SHADER_CORE_ZFLAG_EN adds a per-lane registered zero flag output (result_zero).
module shader_core_simd #(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [15:0]               instr,
   input  logic                      instr_valid,
   output logic                      instr_ready,
   input  logic                      ld_valid,
   output logic                      ld_ready,
   input  logic [LANE_W-1:0]         ld_lane,
   input  logic [2:0]                ld_addr,
   input  logic [DATA_W-1:0]         ld_data,
   output logic                      result_valid,
   input  logic                      result_ready,
   output logic [LANES*DATA_W-1:0]   result_data,
   output logic [2:0]                result_rd
`ifdef SHADER_CORE_ZFLAG_EN
   ,
   output logic [LANES-1:0]          result_zero
`endif
);
   localparam int SH_W = $clog2(DATA_W);

   logic       ex_valid, ex_we, ex_shreg;
   logic [2:0] ex_op, ex_rd;
   logic       adv, accept, ld_fire;
   logic [2:0] in_rs1, in_rs2;
   logic       unused_rsvd;

   assign in_rs1      = instr[12:10];
   assign in_rs2      = instr[9:7];
   assign unused_rsvd = ^instr[3:2];

   // Handshake readiness never depends on the instruction word itself.
   always_comb begin
      adv         = ex_valid && (!result_valid || result_ready);
      instr_ready = (!ex_valid || adv) && !ld_valid;
      ld_ready    = !(adv && ex_we);
      accept      = instr_valid && instr_ready;
      ld_fire     = ld_valid && ld_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_op        <= '0;
         ex_rd        <= '0;
         ex_we        <= 1'b0;
         ex_shreg     <= 1'b0;
         result_valid <= 1'b0;
         result_rd    <= '0;
      end else begin
         if (accept) begin
            ex_valid <= 1'b1;
            ex_op    <= instr[15:13];
            ex_rd    <= instr[6:4];
            ex_shreg <= instr[1];
            ex_we    <= instr[0];
         end else if (adv) begin
            ex_valid <= 1'b0;
         end
         if (adv) begin
            result_valid <= 1'b1;
            result_rd    <= ex_rd;
         end else if (result_ready) begin
            result_valid <= 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] rf [8];
      logic [DATA_W-1:0] ex_a, ex_b, alu, opnd_a, opnd_b, res;
      logic [SH_W-1:0]   shamt;

      always_comb begin
         shamt = ex_shreg ? ex_b[SH_W-1:0] : SH_W'(1);
         case (ex_op)
            3'd0:    alu = ex_a + ex_b;
            3'd1:    alu = ex_a - ex_b;
            3'd2:    alu = ex_a & ex_b;
            3'd3:    alu = ex_a | ex_b;
            3'd4:    alu = ex_a ^ ex_b;
            3'd5:    alu = ex_a * ex_b;
            3'd6:    alu = ex_a << shamt;
            default: alu = ex_a >> shamt;
         endcase
      end

      // Bypass the instruction retiring this edge so dependent issue needs no bubble.
      always_comb begin
         opnd_a = rf[in_rs1];
         opnd_b = rf[in_rs2];
         if (adv && ex_we && (ex_rd == in_rs1)) opnd_a = alu;
         if (adv && ex_we && (ex_rd == in_rs2)) opnd_b = alu;
      end

      always_ff @(posedge clk) begin
         if (accept) begin
            ex_a <= opnd_a;
            ex_b <= opnd_b;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            res <= '0;
         end else begin
            if (adv && ex_we) rf[ex_rd] <= alu;
            if (ld_fire && (ld_lane == LANE_W'(gi))) rf[ld_addr] <= ld_data;
            if (adv) res <= alu;
         end
      end

      assign result_data[gi*DATA_W +: DATA_W] = res;

`ifdef SHADER_CORE_ZFLAG_EN
      logic zero;
      always_ff @(posedge clk) begin
         if (rst)      zero <= 1'b0;
         else if (adv) zero <= (alu == '0);
      end
      assign result_zero[gi] = zero;
`endif
   end
endmodule

// File: tb/tb_shader_core_simd.sv
// Self-checking bench for shader_core_simd: directed scenarios plus a randomized stream
// scored against a sequential-semantics reference model.
module tb_shader_core_simd;
   localparam int DATA_W = 16;
   localparam int LANES  = 4;
   localparam int LANE_W = 2;
   localparam int ENT_W  = LANES + 3 + LANES*DATA_W;
   typedef logic [ENT_W-1:0] ent_t;

   logic                    clk, rst;
   logic [15:0]             instr;
   logic                    instr_valid, instr_ready, ld_valid, ld_ready;
   logic [LANE_W-1:0]       ld_lane;
   logic [2:0]              ld_addr;
   logic [DATA_W-1:0]       ld_data;
   logic                    result_valid, result_ready;
   logic [LANES*DATA_W-1:0] result_data;
   logic [2:0]              result_rd;
`ifdef SHADER_CORE_ZFLAG_EN
   logic [LANES-1:0]        result_zero;
`endif

   int vectors = 0, miscompares = 0, issued = 0, loaded = 0;
   logic [DATA_W-1:0] mrf [LANES][8];
   ent_t exp_q[$], obs_q[$];

   shader_core_simd #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_lane(ld_lane), .ld_addr(ld_addr), .ld_data(ld_data),
      .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
      .result_rd(result_rd)
`ifdef SHADER_CORE_ZFLAG_EN
      , .result_zero(result_zero)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DATA_W-1:0] ref_alu(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b, input logic shreg);
      longint unsigned ua, ub, r;
      int sh;
      ua = 64'(a);
      ub = 64'(b);
      sh = shreg ? int'(ub % 64'(DATA_W)) : 1;
      case (op)
         3'd0:    r = ua + ub;
         3'd1:    r = ua + (64'd1 << DATA_W) - ub;
         3'd2:    r = ua & ub;
         3'd3:    r = ua | ub;
         3'd4:    r = ua ^ ub;
         3'd5:    r = ua * ub;
         3'd6:    r = ua << sh;
         default: r = ua >> sh;
      endcase
      return r[DATA_W-1:0];
   endfunction

   function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [2:0] rd, input logic shreg, input logic we);
      return {op, rs1, rs2, rd, 2'b00, shreg, we};
   endfunction

   // Instructions take effect in accept order; entry = {zero flags, rd, lane data}.
   task automatic model_issue(input logic [15:0] ins);
      logic [DATA_W-1:0] res [LANES];
      ent_t e;
      e = '0;
      for (int l = 0; l < LANES; l++) begin
         res[l] = ref_alu(ins[15:13], mrf[l][ins[12:10]], mrf[l][ins[9:7]], ins[1]);
         e[l*DATA_W +: DATA_W] = res[l];
`ifdef SHADER_CORE_ZFLAG_EN
         e[LANES*DATA_W + 3 + l] = (res[l] == '0);
`endif
      end
      e[LANES*DATA_W +: 3] = ins[6:4];
      if (ins[0]) for (int l = 0; l < LANES; l++) mrf[l][ins[6:4]] = res[l];
      exp_q.push_back(e);
   endtask

   task automatic step();
      ent_t o;
      logic [LANES-1:0] zf;
      @(negedge clk);
      if (rst) begin
         for (int l = 0; l < LANES; l++) for (int r = 0; r < 8; r++) mrf[l][r] = '0;
         exp_q.delete();
         obs_q.delete();
      end else begin
`ifdef SHADER_CORE_ZFLAG_EN
         zf = result_zero;
`else
         zf = '0;
`endif
         if (result_valid && result_ready) begin
            o = {zf, result_rd, result_data};
            obs_q.push_back(o);
         end
         if (instr_valid && instr_ready) begin
            model_issue(instr);
            issued++;
         end
         if (ld_valid && ld_ready) begin
            if (int'(ld_lane) < LANES) mrf[ld_lane][ld_addr] = ld_data;
            loaded++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [15:0] ins);
      int start;
      start = issued;
      instr = ins;
      instr_valid = 1'b1;
      for (int c = 0; c < 50; c++) begin
         step();
         if (issued != start) break;
      end
      instr_valid = 1'b0;
   endtask

   task automatic load(input int lane, input int addr, input logic [DATA_W-1:0] data);
      int start;
      start = loaded;
      ld_valid = 1'b1;
      ld_lane = LANE_W'(lane);
      ld_addr = 3'(addr);
      ld_data = data;
      for (int c = 0; c < 20; c++) begin
         step();
         if (loaded != start) break;
      end
      ld_valid = 1'b0;
   endtask

   task automatic drain();
      result_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (obs_q.size() >= exp_q.size() && !result_valid) break;
         step();
      end
   endtask

   task automatic test_reset();
      ent_t e, o;
      rst = 1'b1; instr = '0; instr_valid = 1'b0; ld_valid = 1'b0;
      ld_lane = '0; ld_addr = '0; ld_data = '0; result_ready = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
      vectors++; if (result_data !== '0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", result_data); end
      vectors++; if (result_rd !== 3'd0) begin miscompares++; $display("FAIL reset_rd got=%0d exp=0", result_rd); end
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_instr_ready got=%b exp=1", instr_ready); end
      vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
      for (int r = 0; r < 8; r++) offer(mk(3'd3, 3'(r), 3'(r), 3'd6, 1'b0, 1'b0));
      drain();
      vectors++; if (obs_q.size() != 8) begin miscompares++; $display("FAIL reset_count got=%0d exp=8", obs_q.size()); end
      for (int k = 0; k < obs_q.size(); k++) begin
         vectors++;
         if (obs_q[k][LANES*DATA_W-1:0] !== '0) begin miscompares++; $display("FAIL reset_reg r%0d got=%h exp=0", k, obs_q[k][LANES*DATA_W-1:0]); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL reset_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_alu();
      logic [DATA_W-1:0] init [7] = '{16'd5, 16'd2, 16'd15, 16'd8, 16'd10, 16'd6, 16'd3};
      logic [DATA_W-1:0] want [8] = '{16'd7, 16'd7, 16'd2, 16'd3, 16'd15, 16'd24, 16'd30, 16'd3};
      logic [2:0] s1 [8] = '{3'd0, 3'd2, 3'd4, 3'd1, 3'd0, 3'd3, 3'd2, 3'd5};
      logic [2:0] s2 [8] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd0};
      ent_t e, o;
      for (int l = 0; l < LANES; l++)
         for (int r = 0; r < 7; r++) load(l, r, (l == 0) ? init[r] : DATA_W'($urandom));
      for (int k = 0; k < 8; k++) offer(mk(3'(k), s1[k], s2[k], 3'd7, 1'b0, 1'b1));
      drain();
      vectors++; if (obs_q.size() != 8) begin miscompares++; $display("FAIL alu_count got=%0d exp=8", obs_q.size()); end
      for (int k = 0; k < obs_q.size() && k < 8; k++) begin
         vectors++;
         if (obs_q[k][DATA_W-1:0] !== want[k]) begin miscompares++; $display("FAIL alu_op%0d lane0 got=%0d exp=%0d", k, obs_q[k][DATA_W-1:0], want[k]); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL alu_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] want [3] = '{16'h0000, 16'h0002, 16'h0001};
      ent_t e, o;
      for (int l = 0; l < LANES; l++) begin
         load(l, 0, (l == 0) ? 16'hFFFF : DATA_W'($urandom));
         load(l, 1, (l == 0) ? 16'h0001 : DATA_W'($urandom));
      end
      offer(mk(3'd0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1));
      offer(mk(3'd1, 3'd1, 3'd0, 3'd3, 1'b0, 1'b1));
      offer(mk(3'd5, 3'd0, 3'd0, 3'd4, 1'b0, 1'b1));
      drain();
      vectors++; if (obs_q.size() != 3) begin miscompares++; $display("FAIL wrap_count got=%0d exp=3", obs_q.size()); end
      for (int k = 0; k < obs_q.size() && k < 3; k++) begin
         vectors++;
         if (obs_q[k][DATA_W-1:0] !== want[k]) begin miscompares++; $display("FAIL wrap_%0d lane0 got=%h exp=%h", k, obs_q[k][DATA_W-1:0], want[k]); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL wrap_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back();
      int start;
      ent_t e, o;
      for (int l = 0; l < LANES; l++) load(l, 0, DATA_W'(3 + l));
      result_ready = 1'b1;
      instr = mk(3'd0, 3'd0, 3'd0, 3'd1, 1'b0, 1'b1);
      instr_valid = 1'b1;
      start = issued;
      step();
      vectors++; if (issued != start + 1) begin miscompares++; $display("FAIL b2b_first_accept got=%0d exp=%0d", issued - start, 1); end
      instr = mk(3'd0, 3'd1, 3'd1, 3'd2, 1'b0, 1'b1);
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_instr_ready got=%b exp=1", instr_ready); end
      step();
      vectors++; if (issued != start + 2) begin miscompares++; $display("FAIL b2b_second_accept got=%0d exp=%0d", issued - start, 2); end
      instr_valid = 1'b0;
      drain();
      vectors++; if (obs_q.size() != 2) begin miscompares++; $display("FAIL b2b_count got=%0d exp=2", obs_q.size()); end
      if (obs_q.size() == 2) begin
         vectors++; if (obs_q[0][DATA_W-1:0] !== 16'd6) begin miscompares++; $display("FAIL b2b_r1 got=%0d exp=6", obs_q[0][DATA_W-1:0]); end
         vectors++; if (obs_q[1][DATA_W-1:0] !== 16'd12) begin miscompares++; $display("FAIL b2b_r2 got=%0d exp=12", obs_q[1][DATA_W-1:0]); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL b2b_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_stall();
      int start;
      ent_t e, o;
      result_ready = 1'b0;
      offer(mk(3'd0, 3'd0, 3'd0, 3'd1, 1'b0, 1'b1));
      offer(mk(3'd0, 3'd1, 3'd0, 3'd2, 1'b0, 1'b1));
      instr = mk(3'd4, 3'd2, 3'd1, 3'd3, 1'b0, 1'b1);
      instr_valid = 1'b1;
      start = issued;
      for (int c = 0; c < 3; c++) begin
         vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL stall_instr_ready cyc%0d got=%b exp=0", c, instr_ready); end
         vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold cyc%0d got=%b exp=1", c, result_valid); end
         step();
      end
      vectors++; if (issued != start) begin miscompares++; $display("FAIL stall_no_accept got=%0d exp=0", issued - start); end
      result_ready = 1'b1;
      for (int c = 0; c < 20 && issued == start; c++) step();
      instr_valid = 1'b0;
      drain();
      vectors++; if (obs_q.size() != 3) begin miscompares++; $display("FAIL stall_count got=%0d exp=3", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL stall_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_shift_lanes();
      int start;
      ent_t e, o;
      for (int l = 0; l < LANES; l++) begin
         load(l, 0, DATA_W'(l + 1));
         load(l, 1, 16'd10);
         load(l, 7, DATA_W'(16'h00A0 + l));
      end
      offer(mk(3'd6, 3'd0, 3'd1, 3'd7, 1'b1, 1'b0));
      offer(mk(3'd3, 3'd7, 3'd7, 3'd6, 1'b0, 1'b0));
      drain();
      vectors++; if (obs_q.size() != 2) begin miscompares++; $display("FAIL shift_count got=%0d exp=2", obs_q.size()); end
      for (int l = 0; l < LANES && obs_q.size() == 2; l++) begin
         vectors++;
         if (obs_q[0][l*DATA_W +: DATA_W] !== DATA_W'((l + 1) * 1024)) begin miscompares++; $display("FAIL shift_lane%0d got=%h exp=%h", l, obs_q[0][l*DATA_W +: DATA_W], (l + 1) * 1024); end
         vectors++;
         if (obs_q[1][l*DATA_W +: DATA_W] !== DATA_W'(16'h00A0 + l)) begin miscompares++; $display("FAIL shift_r7_kept lane%0d got=%h exp=%h", l, obs_q[1][l*DATA_W +: DATA_W], 16'h00A0 + l); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL shift_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
      offer(mk(3'd0, 3'd0, 3'd1, 3'd7, 1'b0, 1'b1));
      ld_valid = 1'b1; ld_lane = 2'd2; ld_addr = 3'd7; ld_data = 16'h1234;
      vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL ld_block got=%b exp=0", ld_ready); end
      start = loaded;
      for (int c = 0; c < 20 && loaded == start; c++) step();
      ld_valid = 1'b0;
      offer(mk(3'd3, 3'd7, 3'd7, 3'd6, 1'b0, 1'b0));
      drain();
      vectors++; if (obs_q.size() != 2) begin miscompares++; $display("FAIL ld_count got=%0d exp=2", obs_q.size()); end
      for (int l = 0; l < LANES && obs_q.size() == 2; l++) begin
         vectors++;
         if (obs_q[1][l*DATA_W +: DATA_W] !== ((l == 2) ? 16'h1234 : DATA_W'(l + 11))) begin miscompares++; $display("FAIL ld_r7 lane%0d got=%h", l, obs_q[1][l*DATA_W +: DATA_W]); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL ld_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random();
      int start, total;
      ent_t e, o;
      for (int l = 0; l < LANES; l++)
         for (int r = 0; r < 8; r++) load(l, r, DATA_W'($urandom));
      instr_valid = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         result_ready = ($urandom_range(0, 3) != 0);
         if (!instr_valid && $urandom_range(0, 4) != 0) begin
            instr = 16'($urandom);
            instr_valid = 1'b1;
         end
         start = issued;
         step();
         if (issued != start) instr_valid = 1'b0;
      end
      instr_valid = 1'b0;
      drain();
      total = exp_q.size();
      vectors++; if (obs_q.size() != total || total == 0) begin miscompares++; $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), total); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL random_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_midflight();
      ent_t e, o;
      for (int l = 0; l < LANES; l++) load(l, 3, DATA_W'($urandom) | 16'h0001);
      result_ready = 1'b0;
      offer(mk(3'd0, 3'd3, 3'd3, 3'd5, 1'b0, 1'b1));
      offer(mk(3'd3, 3'd3, 3'd5, 3'd4, 1'b0, 1'b1));
      vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_full got=%b exp=1", result_valid); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got=%b exp=0", result_valid); end
      vectors++; if (result_data !== '0) begin miscompares++; $display("FAIL midrst_data got=%h exp=0", result_data); end
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got=%b exp=1", instr_ready); end
      result_ready = 1'b1;
      offer(mk(3'd3, 3'd3, 3'd3, 3'd6, 1'b0, 1'b0));
      offer(mk(3'd3, 3'd5, 3'd4, 3'd6, 1'b0, 1'b0));
      for (int l = 0; l < LANES; l++) load(l, 0, DATA_W'($urandom) | 16'h0100);
      offer(mk(3'd1, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0));
      drain();
      vectors++; if (obs_q.size() != 3) begin miscompares++; $display("FAIL midrst_count got=%0d exp=3", obs_q.size()); end
      for (int k = 0; k < obs_q.size(); k++) begin
         vectors++;
         if (obs_q[k][LANES*DATA_W-1:0] !== '0) begin miscompares++; $display("FAIL midrst_zero_data %0d got=%h exp=0", k, obs_q[k][LANES*DATA_W-1:0]); end
`ifdef SHADER_CORE_ZFLAG_EN
         vectors++;
         if (obs_q[k][ENT_W-1 -: LANES] !== {LANES{1'b1}}) begin miscompares++; $display("FAIL zflag %0d got=%b exp=all ones", k, obs_q[k][ENT_W-1 -: LANES]); end
`endif
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin miscompares++; $display("FAIL midrst_result got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_wrap();
      test_back_to_back();
      test_stall();
      test_shift_lanes();
      test_random();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
